// File: rtl/srambank_arbiter_2p.sv
// Two-requester round-robin front end for a single-port synchronous SRAM bank.
// Zero-fills the whole bank after reset, then forwards one command per cycle.
module srambank_arbiter_2p #(
    parameter int AW = 8,
    parameter int DW = 36
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      rq_valid,
    input  logic [1:0]      rq_we,
    input  logic [2*AW-1:0] rq_addr,
    input  logic [2*DW-1:0] rq_wdata,
    output logic [1:0]      rq_ready,
    output logic [1:0]      rs_valid,
    output logic [DW-1:0]   rs_data,
    output logic            init_done,
    output logic            bank_sel,
    output logic            bank_read,
    output logic            bank_write,
    output logic [AW-1:0]   bank_addr,
    output logic [DW-1:0]   bank_wd,
    input  logic [DW-1:0]   bank_dout
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state_q;
    logic [AW-1:0]   init_cnt_q;
    logic            init_done_q;
    logic            rr_last_q;
    logic [1:0]      rs_valid_q;
    logic [1:0]      rs_valid_d;

    logic            gnt_any;
    logic            gnt_idx;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wd;

    // Grant is derived from rq_valid alone so that fields of idle requesters never reach the bank.
    always_comb begin
        gnt_any = (state_q == ST_RUN) && (rq_valid != 2'b00);
        gnt_idx = 1'b0;
        unique case (rq_valid)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~rr_last_q;
            default: gnt_idx = 1'b0;
        endcase
        sel_we   = gnt_idx ? rq_we[1]           : rq_we[0];
        sel_addr = gnt_idx ? rq_addr[AW +: AW]  : rq_addr[0 +: AW];
        sel_wd   = gnt_idx ? rq_wdata[DW +: DW] : rq_wdata[0 +: DW];
    end

    always_comb begin
        rq_ready   = 2'b00;
        rs_valid_d = 2'b00;
        bank_sel   = 1'b0;
        bank_read  = 1'b0;
        bank_write = 1'b0;
        bank_addr  = '0;
        bank_wd    = '0;
        if (state_q == ST_INIT) begin
            bank_sel   = 1'b1;
            bank_write = 1'b1;
            bank_addr  = init_cnt_q;
        end else if (gnt_any) begin
            rq_ready   = gnt_idx ? 2'b10 : 2'b01;
            bank_sel   = 1'b1;
            bank_write = sel_we;
            bank_read  = ~sel_we;
            bank_addr  = sel_addr;
            bank_wd    = sel_wd;
            rs_valid_d = sel_we ? 2'b00 : rq_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rr_last_q   <= 1'b1;
            rs_valid_q  <= 2'b00;
        end else begin
            rs_valid_q <= rs_valid_d;
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (&init_cnt_q) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    if (gnt_any) rr_last_q <= gnt_idx;
                end
            endcase
        end
    end

    // Data is passed straight through; the bank macro holds its output between reads.
    assign rs_valid  = rs_valid_q;
    assign rs_data   = bank_dout;
    assign init_done = init_done_q;

endmodule
